// File: rtl/full_subtractor_case.sv
// Registered ripple-borrow subtractor: {Borr, Diff} = A - B - Bin, with each bit-cell built as an explicit truth-table case.
// Latency 1 when REGISTER_OUT=1 (0 in bypass); one result per cycle, no backpressure, no enable.
module full_subtractor_case #(
  parameter int WIDTH        = 1,
  parameter bit REGISTER_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Borr
);

  logic [WIDTH-1:0] diff_c;
  logic             borr_c;

  // Borrow ripples LSB to MSB; bi carries the borrow into the current cell.
  always_comb begin
    logic bi;
    diff_c = '0;
    borr_c = 1'b0;
    bi     = Bin;
    for (int i = 0; i < WIDTH; i++) begin
      case ({A[i], B[i], bi})
        3'b000:  begin diff_c[i] = 1'b0; bi = 1'b0; end
        3'b001:  begin diff_c[i] = 1'b1; bi = 1'b1; end
        3'b010:  begin diff_c[i] = 1'b1; bi = 1'b1; end
        3'b011:  begin diff_c[i] = 1'b0; bi = 1'b1; end
        3'b100:  begin diff_c[i] = 1'b1; bi = 1'b0; end
        3'b101:  begin diff_c[i] = 1'b0; bi = 1'b0; end
        3'b110:  begin diff_c[i] = 1'b0; bi = 1'b0; end
        3'b111:  begin diff_c[i] = 1'b1; bi = 1'b1; end
        default: begin diff_c[i] = 1'b0; bi = 1'b0; end
      endcase
    end
    borr_c = bi;
  end

  generate
    if (REGISTER_OUT) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          Diff <= '0;
          Borr <= 1'b0;
        end else begin
          Diff <= diff_c;
          Borr <= borr_c;
        end
      end
    end else begin : g_bypass
      assign Diff = diff_c;
      assign Borr = borr_c;
    end
  endgenerate

endmodule

// File: tb/tb_full_subtractor_case.sv
// Scoreboard bench for full_subtractor_case: 1/8/16-bit registered instances plus a 1-bit bypass instance.
module tb_full_subtractor_case;

  logic clk;
  logic rst;
  logic bclk;
  logic brst;

  logic [0:0]  a1, b1, d1;
  logic        bin1, br1;
  logic [7:0]  a8, b8, d8;
  logic        bin8, br8;
  logic [15:0] a16, b16, d16;
  logic        bin16, br16;
  logic [0:0]  ab, bb, db;
  logic        binb, brb;

  logic iv1, iv8, iv16;
  logic ov1, ov8, ov16;

  logic [1:0]  q1[$];
  logic [8:0]  q8[$];
  logic [16:0] q16[$];

  int checks = 0;
  int errors = 0;

  full_subtractor_case #(.WIDTH(1), .REGISTER_OUT(1'b1)) u1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Bin(bin1), .Diff(d1), .Borr(br1));
  full_subtractor_case #(.WIDTH(8), .REGISTER_OUT(1'b1)) u8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Bin(bin8), .Diff(d8), .Borr(br8));
  full_subtractor_case #(.WIDTH(16), .REGISTER_OUT(1'b1)) u16 (
    .clk(clk), .rst(rst), .A(a16), .B(b16), .Bin(bin16), .Diff(d16), .Borr(br16));
  full_subtractor_case #(.WIDTH(1), .REGISTER_OUT(1'b0)) ub (
    .clk(bclk), .rst(brst), .A(ab), .B(bb), .Bin(binb), .Diff(db), .Borr(brb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Valid tracks the one-cycle register stage; reset discards anything in flight.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ov1  <= 1'b0;
      ov8  <= 1'b0;
      ov16 <= 1'b0;
    end else begin
      ov1  <= iv1;
      ov8  <= iv8;
      ov16 <= iv16;
    end
  end

  always @(negedge clk) begin
    if (ov1) begin
      if (q1.size() == 0) check("w1_underflow", 17'd1, 17'd0);
      else check("w1_result", {15'd0, br1, d1}, {15'd0, q1.pop_front()});
    end
    if (ov8) begin
      if (q8.size() == 0) check("w8_underflow", 17'd1, 17'd0);
      else check("w8_result", {8'd0, br8, d8}, {8'd0, q8.pop_front()});
    end
    if (ov16) begin
      if (q16.size() == 0) check("w16_underflow", 17'd1, 17'd0);
      else check("w16_result", {br16, d16}, q16.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "timeout");
  end

  // Expected {borr, diff} for {A,B,Bin} = 0..7.
  logic [1:0] e1 [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
  logic [7:0] va8 [6] = '{8'h00, 8'hFF, 8'h80, 8'h00, 8'h05, 8'h03};
  logic [7:0] vb8 [6] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h03, 8'h05};
  logic       vc8 [6] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
  logic [8:0] ve8 [6] = '{9'h1FF, 9'h000, 9'h07F, 9'h180, 9'h001, 9'h1FE};

  initial begin
    logic [2:0] v;
    rst = 1'b1; bclk = 1'b0; brst = 1'b1;
    iv1 = 1'b0; iv8 = 1'b0; iv16 = 1'b0;
    a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
    a8 = 8'h55; b8 = 8'h01; bin8 = 1'b0;
    a16 = 16'h1234; b16 = 16'h0001; bin16 = 1'b0;
    ab = 1'b1; bb = 1'b1; binb = 1'b1;
    #1;
    check("bypass_111", {15'd0, brb, db}, 17'b11);
    for (int k = 0; k < 8; k++) begin
      v = k[2:0];
      {ab, bb, binb} = v;
      #1;
      check("bypass_sweep", {15'd0, brb, db}, {15'd0, e1[k]});
    end

    repeat (2) @(posedge clk);
    #1;
    check("reset_w1", {15'd0, br1, d1}, 17'd0);
    check("reset_w8", {8'd0, br8, d8}, 17'd0);
    check("reset_w16", {br16, d16}, 17'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c != 0) @(negedge clk);
      if (c < 8) begin
        v = c[2:0];
        {a1, b1, bin1} = v;
        iv1 = 1'b1;
        q1.push_back(e1[c]);
      end else iv1 = 1'b0;
      if (c < 6) begin
        a8 = va8[c]; b8 = vb8[c]; bin8 = vc8[c];
        iv8 = 1'b1;
        q8.push_back(ve8[c]);
      end else iv8 = 1'b0;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      bin16 = 1'($urandom);
      if (c == 18) begin a16 = 16'h0000; b16 = 16'hFFFF; bin16 = 1'b1; end
      if (c == 19) begin a16 = 16'hFFFF; b16 = 16'h0000; bin16 = 1'b0; end
      iv16 = 1'b1;
      q16.push_back({1'b0, a16} - {1'b0, b16} - {16'd0, bin16});
    end
    @(negedge clk);
    iv1 = 1'b0; iv8 = 1'b0; iv16 = 1'b0;
    repeat (2) @(negedge clk);
    check("drain_w1", 17'(q1.size()), 17'd0);
    check("drain_w8", 17'(q8.size()), 17'd0);
    check("drain_w16", 17'(q16.size()), 17'd0);

    a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0;
    a16 = 16'h0000; b16 = 16'h0002; bin16 = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_w8", {8'd0, br8, d8}, {8'd0, 9'h1FF});
    check("pre_reset_w16", {br16, d16}, 17'h1FFFE);
    #2 rst = 1'b1;
    #1;
    check("async_reset_w8", {8'd0, br8, d8}, 17'd0);
    check("async_reset_w16", {br16, d16}, 17'd0);
    @(posedge clk);
    #1;
    check("held_reset_w8", {8'd0, br8, d8}, 17'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("release_w8", {8'd0, br8, d8}, {8'd0, 9'h1FF});
    check("release_w16", {br16, d16}, 17'h1FFFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_subtractor_case.md
# full_subtractor_case

Registered full subtractor. It computes A − B − Bin and returns the difference bit(s) and the borrow-out, with the per-bit function implemented as an explicit 8-entry truth-table case. It is a leaf arithmetic primitive used as a building block for ripple-borrow subtractors and comparator datapaths. Outputs are captured in flops on the system clock and cleared by the system reset.

## Interface
Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64; the default reproduces the classic 1-bit full subtractor.
- REGISTER_OUT, 1, 1 = outputs registered (latency 1); 0 = purely combinational bypass, in which case clk and rst have no effect.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset.
  - One clock; reset is asynchronous and active-high.
  - Clears all output flops immediately.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in, applied at bit 0.
- Diff  output  WIDTH  difference bits.
- Borr  output  1  borrow-out from the MSB.

## Operation
- Bit-cell i, with inputs a=A[i], b=B[i], bi = (i==0 ? Bin : borrow[i-1]), uses a case on {a,b,bi}:
  - 000 -> d=0, bo=0
  - 001 -> d=1, bo=1
  - 010 -> d=1, bo=1
  - 011 -> d=0, bo=1
  - 100 -> d=1, bo=0
  - 101 -> d=0, bo=0
  - 110 -> d=0, bo=0
  - 111 -> d=1, bo=1
- Case default (X/Z on inputs): d=0, bo=0. No latches are permitted.
- Equivalent arithmetic: {Borr, Diff} = (A − B − Bin) modulo 2^(WIDTH+1), computed in two's complement.
  - Borr=1 exactly when A < B + Bin, both sides taken as unsigned.
- The borrow ripples bit 0 -> bit WIDTH−1. Borr is the borrow out of bit WIDTH−1.
- With REGISTER_OUT=1, the combinational result is loaded into the Diff/Borr flops on every rising clk edge. There is no enable, and the output holds until the next edge.

## Timing
- Reset: when rst=1, Diff=0 and Borr=0 asynchronously, with no clock needed. They stay 0 for every clk edge while rst=1.
- Reset release: the first capture happens on the first rising clk edge with rst=0. No extra dead cycles.
- Reset asserted mid-operation: outputs go to 0 at once, and the in-flight result is discarded.
- Latency (REGISTER_OUT=1): the result for inputs sampled at edge N appears after edge N and is stable for one full cycle.
  - Back-to-back input changes every cycle give one result per cycle (throughput 1).
- REGISTER_OUT=0: Diff/Borr follow A/B/Bin combinationally, and rst/clk are ignored.
- Inputs must meet setup/hold to clk. There is no internal synchronization.

## Test plan
- Reset: rst=1 with A=1, B=0, Bin=0, clocking -> Diff=0, Borr=0. Assert rst between edges -> outputs drop to 0 before the next edge.
- Exhaustive 1-bit sweep (WIDTH=1): drive {A,B,Bin}=0..7, one value per cycle. After 1 cycle latency, the result must be:
  - Diff = 0,1,1,0,1,0,0,1
  - Borr = 0,1,1,1,0,0,0,1
- Boundary, WIDTH=8:
  - A=8'h00, B=8'h00, Bin=1 -> Diff=8'hFF, Borr=1.
  - A=8'hFF, B=8'hFF, Bin=0 -> Diff=8'h00, Borr=0.
- Full borrow ripple, WIDTH=8: A=8'h80, B=8'h01, Bin=0 -> Diff=8'h7F, Borr=0. Then A=8'h00, B=8'h80 -> Diff=8'h80, Borr=1.
- Latency/throughput: change inputs every cycle with random WIDTH=16 operands. Each output must equal the A−B−Bin reference of the previous edge, with no bubbles.
- Bypass (REGISTER_OUT=0): A=1, B=1, Bin=1 -> Diff=1, Borr=1 in the same timestep, with rst held at 1 and no clock.
